// File: rtl/exc_flush_ctrl_pkg.sv
// Shared types and constants for the exception/interrupt flush sequencer.
package exc_flush_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TAKE    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_KERNEL  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'b00,
    CAUSE_IRQ   = 2'b01,
    CAUSE_UNDEF = 2'b10
  } cause_t;

  localparam logic [31:0] DEF_IRQ_VECTOR = 32'h8000_0004;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h8000_0008;
  localparam int          DEF_CNT_W      = 8;

endpackage

// File: rtl/exc_flush_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_en && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/exc_flush_ctrl.sv
// Interrupt / undefined-instruction sequencer: flushes IF/ID and ID/EX, redirects
// the PC to the handler, captures EPC from the flushed bubble and handles ERET.
//
// state   | meaning
// IDLE    | user code; waiting for an unstalled, non-branch cycle with an event
// TAKE    | flush + redirect pulse to the handler vector
// CAPTURE | ID/EX holds the victim's PC+4; latch it into epc
// KERNEL  | handler running; events ignored until an unstalled ERET
module exc_flush_ctrl
  import exc_flush_ctrl_pkg::*;
#(
  parameter logic [31:0] IRQ_VECTOR = DEF_IRQ_VECTOR,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
  parameter int          CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             irq_in,
  input  logic             undef_in,
  input  logic             eret_in,
  input  logic             stall_in,
  input  logic             branch_ex_in,
  input  logic [31:0]      id_ex_pc_plus_4_in,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pc_redirect,
  output logic [31:0]      pc_target,
  output logic [31:0]      epc,
  output logic [1:0]       exc_cause,
  output logic             kernel_mode,
  output logic [CNT_W-1:0] irq_count
);

  state_t      r_state;
  state_t      w_state_nxt;
  cause_t      r_pend_cause;
  cause_t      r_exc_cause;
  logic        r_if_id_flush;
  logic        r_id_ex_flush;
  logic        r_pc_redirect;
  logic [31:0] r_pc_target;
  logic [31:0] r_epc;
  logic        r_kernel_mode;

  logic        w_take;
  logic        w_eret;
  cause_t      w_take_cause;
  cause_t      w_pend_cause_nxt;
  cause_t      w_exc_cause_nxt;
  logic [31:0] w_pc_target_nxt;
  logic [31:0] w_epc_nxt;
  logic        w_kernel_nxt;
  logic        w_cnt_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_take           = 1'b0;
    w_eret           = 1'b0;
    w_take_cause     = CAUSE_IRQ;
    w_pend_cause_nxt = r_pend_cause;
    w_exc_cause_nxt  = r_exc_cause;
    w_pc_target_nxt  = r_pc_target;
    w_epc_nxt        = r_epc;
    w_kernel_nxt     = r_kernel_mode;

    case (r_state)
      ST_IDLE: begin
        // irq is level-sensitive and not latched: a deferred irq must still be high
        if ((undef_in || irq_in) && !stall_in && !branch_ex_in) begin
          w_take           = 1'b1;
          w_take_cause     = undef_in ? CAUSE_UNDEF : CAUSE_IRQ;
          w_pend_cause_nxt = w_take_cause;
          w_pc_target_nxt  = (w_take_cause == CAUSE_UNDEF) ? EXC_VECTOR : IRQ_VECTOR;
          w_kernel_nxt     = 1'b1;
          w_state_nxt      = ST_TAKE;
        end
      end
      ST_TAKE: begin
        w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_epc_nxt       = id_ex_pc_plus_4_in;
        w_exc_cause_nxt = r_pend_cause;
        w_state_nxt     = ST_KERNEL;
      end
      ST_KERNEL: begin
        if (eret_in && !stall_in) begin
          w_eret          = 1'b1;
          w_pc_target_nxt = r_epc;
          w_kernel_nxt    = 1'b0;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_if_id_flush <= 1'b0;
      r_id_ex_flush <= 1'b0;
      r_pc_redirect <= 1'b0;
      r_pc_target   <= '0;
      r_epc         <= '0;
      r_exc_cause   <= CAUSE_NONE;
      r_pend_cause  <= CAUSE_NONE;
      r_kernel_mode <= 1'b0;
    end else begin
      r_if_id_flush <= w_take || w_eret;
      r_id_ex_flush <= w_take;
      r_pc_redirect <= w_take || w_eret;
      r_pc_target   <= w_pc_target_nxt;
      r_epc         <= w_epc_nxt;
      r_exc_cause   <= w_exc_cause_nxt;
      r_pend_cause  <= w_pend_cause_nxt;
      r_kernel_mode <= w_kernel_nxt;
    end
  end

  assign w_cnt_en = w_take && (w_take_cause == CAUSE_IRQ);

  sat_counter #(
    .W (CNT_W)
  ) u_irq_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_cnt_en),
    .o_count (irq_count)
  );

  assign if_id_flush = r_if_id_flush;
  assign id_ex_flush = r_id_ex_flush;
  assign pc_redirect = r_pc_redirect;
  assign pc_target   = r_pc_target;
  assign epc         = r_epc;
  assign exc_cause   = r_exc_cause;
  assign kernel_mode = r_kernel_mode;

endmodule

// File: tb/tb_exc_flush_ctrl.sv
// Directed bench for exc_flush_ctrl with a cycle-level reference model.
module tb_exc_flush_ctrl;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             irq_in = 1'b0;
  logic             undef_in = 1'b0;
  logic             eret_in = 1'b0;
  logic             stall_in = 1'b0;
  logic             branch_ex_in = 1'b0;
  logic [31:0]      id_ex_pc_plus_4_in = '0;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             pc_redirect;
  logic [31:0]      pc_target;
  logic [31:0]      epc;
  logic [1:0]       exc_cause;
  logic             kernel_mode;
  logic [CNT_W-1:0] irq_count;

  int total = 0;
  int bad   = 0;

  exc_flush_ctrl #(.CNT_W(CNT_W)) dut (
    .clk                (clk),
    .reset              (reset),
    .irq_in             (irq_in),
    .undef_in           (undef_in),
    .eret_in            (eret_in),
    .stall_in           (stall_in),
    .branch_ex_in       (branch_ex_in),
    .id_ex_pc_plus_4_in (id_ex_pc_plus_4_in),
    .if_id_flush        (if_id_flush),
    .id_ex_flush        (id_ex_flush),
    .pc_redirect        (pc_redirect),
    .pc_target          (pc_target),
    .epc                (epc),
    .exc_cause          (exc_cause),
    .kernel_mode        (kernel_mode),
    .irq_count          (irq_count)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model. m_age: -1 not in an entry sequence, 0 = flush cycle,
  // 1 = capture cycle. Kernel with m_age=-1 means handler code running.
  logic        m_ifid = 0, m_idex = 0, m_redir = 0, m_kernel = 0;
  logic [31:0] m_target = 0, m_epc = 0;
  logic [1:0]  m_cause = 0, m_pend = 0;
  int          m_count = 0;
  int          m_age = -1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ifid = 0; m_idex = 0; m_redir = 0; m_kernel = 0;
      m_target = 0; m_epc = 0; m_cause = 0; m_pend = 0;
      m_count = 0; m_age = -1;
    end else begin
      int age_prev;
      age_prev = m_age;
      m_ifid = 0; m_idex = 0; m_redir = 0;
      if (age_prev == 0) begin
        m_age = 1;
      end else if (age_prev == 1) begin
        m_epc   = id_ex_pc_plus_4_in;
        m_cause = m_pend;
        m_age   = -1;
      end else if (!m_kernel) begin
        if ((undef_in || irq_in) && !stall_in && !branch_ex_in) begin
          m_pend   = undef_in ? 2'b10 : 2'b01;
          m_target = undef_in ? 32'h8000_0008 : 32'h8000_0004;
          m_ifid = 1; m_idex = 1; m_redir = 1; m_kernel = 1;
          if (!undef_in && m_count < CNT_MAX) m_count = m_count + 1;
          m_age = 0;
        end
      end else if (eret_in && !stall_in) begin
        m_ifid = 1; m_redir = 1;
        m_target = m_epc;
        m_kernel = 0;
      end
    end
  end

  always @(negedge clk) begin
    cmp("cyc_if_id_flush", {31'b0, if_id_flush}, {31'b0, m_ifid});
    cmp("cyc_id_ex_flush", {31'b0, id_ex_flush}, {31'b0, m_idex});
    cmp("cyc_pc_redirect", {31'b0, pc_redirect}, {31'b0, m_redir});
    cmp("cyc_pc_target",   pc_target, m_target);
    cmp("cyc_epc",         epc, m_epc);
    cmp("cyc_exc_cause",   {30'b0, exc_cause}, {30'b0, m_cause});
    cmp("cyc_kernel_mode", {31'b0, kernel_mode}, {31'b0, m_kernel});
    cmp("cyc_irq_count",   {24'b0, irq_count}, m_count);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    #1 reset = 1'b0;
    cyc(2);
    cmp("rst_ifid", {31'b0, if_id_flush}, 32'd0);
    cmp("rst_redir", {31'b0, pc_redirect}, 32'd0);
    cmp("rst_target", pc_target, 32'd0);
    cmp("rst_epc", epc, 32'd0);
    cmp("rst_cause", {30'b0, exc_cause}, 32'd0);
    cmp("rst_kernel", {31'b0, kernel_mode}, 32'd0);
    cmp("rst_count", {24'b0, irq_count}, 32'd0);
    reset = 1'b1;
    cyc(1);

    // interrupt entry
    irq_in = 1; cyc(1);
    cmp("t1_ifid", {31'b0, if_id_flush}, 32'd1);
    cmp("t1_idex", {31'b0, id_ex_flush}, 32'd1);
    cmp("t1_redir", {31'b0, pc_redirect}, 32'd1);
    cmp("t1_target", pc_target, 32'h8000_0004);
    cmp("t1_count", {24'b0, irq_count}, 32'd1);
    irq_in = 0; id_ex_pc_plus_4_in = 32'h0000_0124; cyc(1);
    cmp("t1_cap_redir", {31'b0, pc_redirect}, 32'd0);
    cyc(1);
    cmp("t1_epc", epc, 32'h0000_0124);
    cmp("t1_cause", {30'b0, exc_cause}, 32'd1);
    cmp("t1_kernel", {31'b0, kernel_mode}, 32'd1);

    // irq ignored in kernel, then ERET and re-take of the held irq
    irq_in = 1; id_ex_pc_plus_4_in = 32'h0000_0999;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      cmp("k_irq_ignored", {31'b0, pc_redirect}, 32'd0);
    end
    eret_in = 1; cyc(1);
    cmp("eret_redir", {31'b0, pc_redirect}, 32'd1);
    cmp("eret_target", pc_target, 32'h0000_0124);
    cmp("eret_ifid", {31'b0, if_id_flush}, 32'd1);
    cmp("eret_idex", {31'b0, id_ex_flush}, 32'd0);
    cmp("eret_kernel", {31'b0, kernel_mode}, 32'd0);
    eret_in = 0; cyc(1);
    cmp("retake_idex", {31'b0, id_ex_flush}, 32'd1);
    cmp("retake_count", {24'b0, irq_count}, 32'd2);
    irq_in = 0; cyc(2);
    cmp("retake_epc", epc, 32'h0000_0999);

    // ERET waits out a stall
    eret_in = 1; stall_in = 1;
    for (int i = 0; i < 2; i++) begin
      cyc(1);
      cmp("eret_stall_wait", {31'b0, pc_redirect}, 32'd0);
    end
    stall_in = 0; cyc(1);
    cmp("eret_after_stall", pc_target, 32'h0000_0999);
    // ERET in IDLE has no effect
    cyc(1);
    cmp("eret_idle_ignored", {31'b0, pc_redirect}, 32'd0);
    eret_in = 0;

    // undefined beats simultaneous irq
    undef_in = 1; irq_in = 1; id_ex_pc_plus_4_in = 32'h0000_0200; cyc(1);
    cmp("undef_target", pc_target, 32'h8000_0008);
    cmp("undef_count", {24'b0, irq_count}, 32'd2);
    undef_in = 0; cyc(2);
    cmp("undef_cause", {30'b0, exc_cause}, 32'd2);
    cmp("undef_epc", epc, 32'h0000_0200);
    eret_in = 1; cyc(1);
    cmp("undef_eret_target", pc_target, 32'h0000_0200);
    eret_in = 0; cyc(1);
    cmp("pend_irq_target", pc_target, 32'h8000_0004);
    cmp("pend_irq_count", {24'b0, irq_count}, 32'd3);
    irq_in = 0; cyc(2);
    eret_in = 1; cyc(1);
    eret_in = 0;

    // stall defers an irq
    irq_in = 1; stall_in = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      cmp("stall_defer", {31'b0, if_id_flush}, 32'd0);
    end
    stall_in = 0; cyc(1);
    cmp("stall_release", {31'b0, if_id_flush}, 32'd1);
    irq_in = 0; cyc(2);
    eret_in = 1; cyc(1);
    eret_in = 0;

    // EX branch defers an undefined-op exception
    undef_in = 1; branch_ex_in = 1; cyc(1);
    cmp("branch_defer", {31'b0, id_ex_flush}, 32'd0);
    branch_ex_in = 0; cyc(1);
    cmp("branch_release", pc_target, 32'h8000_0008);
    undef_in = 0; cyc(2);
    eret_in = 1; cyc(1);
    eret_in = 0;

    // counter saturation
    for (int i = 0; i < 260; i++) begin
      irq_in = 1; cyc(1);
      irq_in = 0; cyc(2);
      eret_in = 1; cyc(1);
      eret_in = 0;
    end
    cmp("sat_count", {24'b0, irq_count}, 32'd255);

    // asynchronous reset while in TAKE
    irq_in = 1; id_ex_pc_plus_4_in = 32'h0000_0444;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    cmp("rst_take_ifid", {31'b0, if_id_flush}, 32'd0);
    cmp("rst_take_redir", {31'b0, pc_redirect}, 32'd0);
    cmp("rst_take_target", pc_target, 32'd0);
    cmp("rst_take_epc", epc, 32'd0);
    cmp("rst_take_kernel", {31'b0, kernel_mode}, 32'd0);
    cmp("rst_take_count", {24'b0, irq_count}, 32'd0);
    irq_in = 0;
    cyc(1);
    reset = 1'b1;
    cyc(1);
    eret_in = 1; cyc(1);
    cmp("rst_idle_eret", {31'b0, pc_redirect}, 32'd0);
    eret_in = 0; irq_in = 1; cyc(1);
    cmp("rst_retake", pc_target, 32'h8000_0004);
    irq_in = 0; cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
